// File: rtl/image_stream_tx.sv
// image_stream_tx
//
// Frame buffer and pixel transmitter for the CNN input path. One IMG_W x IMG_H
// image of PIX_W-bit pixels is loaded through a simple write port. On start,
// the stored frame is streamed in raster order over a valid/ready interface.
// Each pixel is tagged with its row, its column and a last flag.
//
// Ports:
//   clk      - single clock, all logic on the rising edge
//   rst      - synchronous, active-high reset
//   wr_en    - write strobe for the pixel buffer (ignored while busy)
//   wr_addr  - linear write address row*IMG_W+col (out-of-range is ignored)
//   wr_data  - pixel value to write
//   start    - single-cycle request to stream the stored frame
//   busy     - high from the accepted start until the done cycle
//   done     - one-cycle pulse after the final pixel handshake
//   m_valid  - output pixel valid
//   m_ready  - downstream accepts the pixel
//   m_data   - pixel value
//   m_row    - row index of m_data
//   m_col    - column index of m_data
//   m_last   - high with the final pixel of the frame
module image_stream_tx #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [9:0]       wr_addr,
    input  logic [PIX_W-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic [4:0]       m_row,
    output logic [4:0]       m_col,
    output logic             m_last
);

    localparam int         NPIX      = IMG_W * IMG_H;
    localparam logic [9:0] LAST_ADDR = 10'(NPIX - 1);
    localparam logic [9:0] ADDR_LIM  = 10'(NPIX);
    localparam logic [4:0] COL_MAX   = 5'(IMG_W - 1);
    localparam logic [4:0] ROW_MAX   = 5'(IMG_H - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [PIX_W-1:0] mem [0:NPIX-1];

    logic [1:0] state;
    logic [9:0] ptr;
    logic [9:0] ptr_nxt;
    logic [4:0] row_nxt;
    logic [4:0] col_nxt;
    logic       handshake;
    logic       wr_ok;

    // Next raster position. The column wraps at the end of a row and the row
    // advances at the same time. It is only consumed on a non-final
    // handshake, so ptr_nxt never runs past the last pixel.
    always_comb begin
        handshake = m_valid && m_ready;
        ptr_nxt   = ptr + 10'd1;
        row_nxt   = m_row;
        col_nxt   = m_col + 5'd1;
        if (m_col == COL_MAX) begin
            col_nxt = 5'd0;
            row_nxt = m_row + 5'd1;
        end
        wr_ok = wr_en && !busy && (wr_addr < ADDR_LIM);
    end

    // Pixel buffer. It has no reset, so a frame survives an aborted stream.
    // Writes are blocked while busy, which freezes the frame for the whole
    // stream, including the done cycle.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stream control. The output registers always hold the pixel that is
    // currently offered. A handshake reloads them from the next address on
    // the same edge, so there is no bubble between pixels. Pixel 0 is
    // captured on the start edge from the array as it was before that edge.
    // A write on the same edge therefore cannot reach pixel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= 10'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_row   <= 5'd0;
            m_col   <= 5'd0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_STREAM;
                        ptr     <= 10'd0;
                        busy    <= 1'b1;
                        m_valid <= 1'b1;
                        m_data  <= mem[0];
                        m_row   <= 5'd0;
                        m_col   <= 5'd0;
                        m_last  <= (LAST_ADDR == 10'd0);
                    end
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (ptr == LAST_ADDR) begin
                            state   <= ST_DONE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            ptr    <= ptr_nxt;
                            m_data <= mem[ptr_nxt];
                            m_row  <= row_nxt;
                            m_col  <= col_nxt;
                            m_last <= (row_nxt == ROW_MAX) && (col_nxt == COL_MAX);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_tx.sv
// tb_image_stream_tx
//
// Bench for image_stream_tx. The stimulus process loads frames and starts
// streams. Each start pushes the expected beats into a queue. An independent
// monitor process pops one entry per handshake and compares it with the DUT
// output. It also checks stall stability and the timing of the done pulse.
module tb_image_stream_tx;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int PIX_W = 7;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef logic [PIX_W+10:0] beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [9:0]       wr_addr;
    logic [PIX_W-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             m_valid;
    logic             m_ready;
    logic [PIX_W-1:0] m_data;
    logic [4:0]       m_row;
    logic [4:0]       m_col;
    logic             m_last;

    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    int               hs_count = 0;
    int               done_count = 0;
    int               last_hs_cyc = -10;
    int               ready_mode = 0;
    logic [PIX_W-1:0] model [0:NPIX-1];
    beat_t            exp_q [$];

    image_stream_tx #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_row   (m_row),
        .m_col   (m_col),
        .m_last  (m_last)
    );

    // Free-running clock and a cycle counter used to time the done pulse.
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Downstream ready: mode 0 always accepts, mode 1 repeats 1,0,0.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    // One comparison: counts it, and reports it when it differs.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    // Drives one cycle of write/start, entered and left at posedge+1.
    task automatic applyStimulus(input logic wr, input logic [9:0] addr, input logic [PIX_W-1:0] data, input logic st);
        wr_en   = wr;
        wr_addr = addr;
        wr_data = data;
        start   = st;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        start = 1'b0;
    endtask

    // Queues the expected beats of one full frame from the bench's model.
    task automatic pushFrame();
        hs_count = 0;
        for (int i = 0; i < NPIX; i++) begin
            exp_q.push_back({model[i], 5'(i / IMG_W), 5'(i % IMG_W), (i == NPIX - 1)});
        end
    endtask

    task automatic waitBeats(input int n);
        int budget = 0;
        while (hs_count < n && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (hs_count < n) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitBeats: got %0d beats, expected %0d", hs_count, n);
        end
    endtask

    // Waits for the given number of done pulses in total. Then checks that
    // busy has fallen and that every queued beat was delivered.
    task automatic waitFrame(input int exp_done);
        int budget = 0;
        while (done_count < exp_done && budget < 5000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (done_count < exp_done) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitFrame: got %0d done pulses, expected %0d", done_count, exp_done);
        end
        checkOutput("done count", done_count, exp_done);
        checkOutput("busy after done", {31'd0, busy}, 32'd1 - 32'd1);
        checkOutput("queue drained", exp_q.size(), 0);
    endtask

    // Monitor: compares beats against the scoreboard and checks that stalled
    // outputs hold their values, busy during valid, and the done timing.
    initial begin
        logic  stall_prev = 1'b0;
        beat_t stall_snap = '0;
        beat_t got;
        beat_t expv;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                got = {m_data, m_row, m_col, m_last};
                if (stall_prev) begin
                    checkOutput("stall hold", {13'd0, m_valid, got}, {13'd0, 1'b1, stall_snap});
                end
                stall_prev = m_valid && !m_ready;
                stall_snap = got;
                if (m_valid) begin
                    checkOutput("busy with valid", {31'd0, busy}, 32'd1);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected beat: got 0x%0h, expected no beat", got);
                    end else begin
                        expv = exp_q.pop_front();
                        checkOutput($sformatf("beat %0d", hs_count), {14'd0, got}, {14'd0, expv});
                    end
                    if (m_last) begin
                        last_hs_cyc = cyc;
                    end
                    hs_count++;
                end
                if (done) begin
                    done_count++;
                    checkOutput("done timing", cyc, last_hs_cyc + 1);
                    checkOutput("busy at done", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs", {13'd0, busy, done, m_valid, m_data, m_row, m_col, m_last}, 32'd0);
        rst = 1'b0;

        $display("[TB] ramp load and full-rate stream");
        for (int i = 0; i < NPIX; i++) begin
            model[i] = PIX_W'(i % 128);
            applyStimulus(1'b1, 10'(i), PIX_W'(i % 128), 1'b0);
        end
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(1);

        $display("[TB] stream with ready pattern 1,0,0");
        ready_mode = 1;
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(2);
        ready_mode = 0;
        @(posedge clk);
        #1;

        $display("[TB] writes while busy are ignored");
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitBeats(10);
        applyStimulus(1'b1, 10'd5, 7'h55, 1'b0);
        applyStimulus(1'b1, 10'd900, 7'h2A, 1'b0);
        waitFrame(3);
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(4);
        model[5] = 7'h55;
        applyStimulus(1'b1, 10'd5, 7'h55, 1'b0);
        applyStimulus(1'b1, 10'd900, 7'h2A, 1'b0);
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(5);

        $display("[TB] second start mid-stream is ignored");
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitBeats(100);
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(6);

        $display("[TB] reset mid-stream");
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitBeats(300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort outputs", {13'd0, busy, done, m_valid, m_data, m_row, m_col, m_last}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no done after abort", done_count, 6);
        pushFrame();
        applyStimulus(1'b0, 10'd0, '0, 1'b1);
        waitFrame(7);

        $display("[TB] start together with write to last pixel");
        model[NPIX-1] = 7'h7F;
        pushFrame();
        applyStimulus(1'b1, 10'(NPIX - 1), 7'h7F, 1'b1);
        waitFrame(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_stream_tx.md
# image_stream_tx

Frame buffer and pixel transmitter for the CNN input path. It holds one 28x28 image of 7-bit pixels, loaded through a simple write port; the testbench drives this port from an image file. On `start`, it streams the image to the first convolution stage in raster order over a valid/ready interface, tagging each pixel with its row, column and a last flag. It is the sending side of the image-memory interface: it replaces preloading the memory from a file with a timed, handshaked stream.

## Interface
- `IMG_W`, 28, pixels per row
- `IMG_H`, 28, rows per image
- `PIX_W`, 7, bits per pixel
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr_en`  in  1  write strobe for the pixel buffer
- `wr_addr`  in  10  linear address, row*IMG_W+col, range 0..783
- `wr_data`  in  PIX_W  pixel value
- `start`  in  1  single-cycle request to stream the stored frame
- `busy`  out  1  high from the accepted start until done
- `done`  out  1  one-cycle pulse after the final pixel handshake
- `m_valid`  out  1  output pixel valid
- `m_ready`  in  1  downstream accepts the pixel
- `m_data`  out  PIX_W  pixel value
- `m_row`  out  5  row index of `m_data`
- `m_col`  out  5  column index of `m_data`
- `m_last`  out  1  high with pixel 783 (row 27, col 27)

## Operation
- Storage: IMG_W*IMG_H entries of PIX_W bits, register array, asynchronous read.
  - Contents are not cleared by reset.
- Write port:
  - When `wr_en`=1, `busy`=0 and `wr_addr`<784, write `wr_data` to `mem[wr_addr]` at the clock edge.
  - `wr_addr`>=784 is ignored.
  - Writes while `busy`=1 are ignored, so a frame cannot change mid-stream.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: `start`=1 moves to STREAM. Load `m_data`=mem[0], row=0, col=0, `m_valid`=1, `busy`=1.
  - STREAM, handshake (`m_valid`&&`m_ready`) on a pixel other than the last: advance the pointer. col increments; at col==IMG_W-1, col wraps to 0 and row increments. Load the next pixel into the output registers in the same edge, so there is no bubble.
  - STREAM, handshake on the last pixel: `m_valid`→0 and go to DONE.
  - STREAM, no handshake: all output registers hold their values. `m_data`, `m_row`, `m_col` and `m_last` must not change while `m_valid`=1 and `m_ready`=0.
  - DONE: `done`=1 for one cycle, `busy`→0, return to IDLE.
- `start` while `busy`=1 or in DONE is ignored; it is not queued.
- `m_last` = (row==IMG_H-1 && col==IMG_W-1) && `m_valid`.
- Linear pointer is 10 bits. It must never exceed 783 and has no wrap-around beyond the last pixel.
- Simultaneous `wr_en` and `start` in IDLE: the write completes and `start` is accepted in the same cycle. The stream reads the post-write value only for addresses other than 0; pixel 0 is loaded from the pre-write array contents.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_data`=0, `m_row`=0, `m_col`=0, `m_last`=0, FSM=IDLE.
- Reset asserted mid-stream aborts immediately: all outputs return to reset values on that edge and no `done` pulse occurs.
- Start latency: `start` sampled at edge T gives `m_valid`=1 with pixel 0 after edge T (visible in cycle T+1).
- Throughput: 1 pixel/cycle with `m_ready` held high. A full frame takes 784 cycles from first valid to last handshake.
- `done` is high in the cycle after the last handshake edge. `busy` falls on the edge after that, so `busy` and `done` overlap for one cycle.
- Minimum start-to-start period: 784 + 2 cycles.

## Test plan
- Load ramp (mem[i]=i mod 128) via the write port, start, `m_ready`=1 → 784 consecutive beats with `m_data`=i mod 128. Beat 28 has row=1, col=0. `m_last` only on beat 783. `done` pulse exactly 1 cycle after beat 783.
- Same frame with `m_ready` toggling 1,0,0,1… → identical data sequence. Outputs stable during every stall. Frame completes only after 784 accepted beats.
- Write to addr 5 with value 7'h55 and addr 900 while busy, then rerun the stream → beat 5 shows the original value. After return to IDLE, write addr 5=7'h55 → next stream shows 7'h55 at beat 5. Addr 900 never affects the stream.
- Second `start` at beat 100 → ignored. Exactly one `done` pulse. `busy` stays high continuously.
- Assert `rst` at beat 300 for 1 cycle → `m_valid`=0, `busy`=0 and no `done`. A new `start` restarts at pixel 0 with row=0, col=0, and memory contents are preserved.
- `start` asserted on the same cycle as `wr_en`=1 to address 783 with value 7'h7F → the new value appears on `m_last` beat 783.
